// File: rtl/btn_value_counter.sv
// btn_value_counter: synchronised, debounced up/down/clear buttons stepping an 8-bit wrap counter.
// Define BTN_VALUE_COUNTER_AUTO_REPEAT_EN to auto-repeat held up/down presses.
module btn_value_counter #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int DB_W            = 20,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_RATE     = 10000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_up,
    input  logic       btn_dn,
    input  logic       btn_clr,
    output logic [7:0] value,
    output logic       changed
);

    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    // bit 0 = up, bit 1 = dn, bit 2 = clr
    logic [2:0]      raw;
    logic [2:0]      s1;
    logic [2:0]      s2;
    logic [2:0]      db;
    logic [2:0]      db_q;
    logic [2:0]      press;
    logic [DB_W-1:0] cnt [3];
    logic            rep_up;
    logic            rep_dn;
    logic            step_up;
    logic            step_dn;
    logic            step_clr;

    assign raw = {btn_clr, btn_dn, btn_up};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1   <= '0;
            s2   <= '0;
            db   <= '0;
            db_q <= '0;
            for (int i = 0; i < 3; i++) cnt[i] <= '0;
        end else begin
            s1   <= raw;
            s2   <= s1;
            db_q <= db;
            for (int i = 0; i < 3; i++) begin
                if (s2[i] == db[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == DB_LAST) begin
                    db[i]  <= s2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    assign press = db & ~db_q;

`ifdef BTN_VALUE_COUNTER_AUTO_REPEAT_EN
    localparam logic [31:0] FIRE   = 32'(REPEAT_DELAY - 1);
    // after a repeat, restart so the next fire is REPEAT_RATE clocks later
    localparam logic [31:0] RELOAD = 32'(REPEAT_DELAY - REPEAT_RATE);

    logic [31:0] t_up;
    logic [31:0] t_dn;

    assign rep_up = db[0] & ~db[1] & ~press[0] & (t_up == FIRE);
    assign rep_dn = db[1] & ~db[0] & ~press[1] & (t_dn == FIRE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            t_up <= '0;
            t_dn <= '0;
        end else begin
            if (press[0] | ~db[0])
                t_up <= '0;
            else if (t_up == FIRE)
                t_up <= RELOAD;
            else
                t_up <= t_up + 32'd1;

            if (press[1] | ~db[1])
                t_dn <= '0;
            else if (t_dn == FIRE)
                t_dn <= RELOAD;
            else
                t_dn <= t_dn + 32'd1;
        end
    end
`else
    logic unused_rep;
    assign unused_rep = ^{REPEAT_DELAY, REPEAT_RATE};
    assign rep_up     = 1'b0;
    assign rep_dn     = 1'b0;
`endif

    assign step_clr = press[2];
    assign step_up  = press[0] | rep_up;
    assign step_dn  = press[1] | rep_dn;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value   <= 8'h00;
            changed <= 1'b0;
        end else begin
            changed <= 1'b0;
            if (step_clr) begin
                value   <= 8'h00;
                changed <= 1'b1;
            end else if (step_up & step_dn) begin
                value   <= value;
            end else if (step_up) begin
                value   <= value + 8'd1;
                changed <= 1'b1;
            end else if (step_dn) begin
                value   <= value - 8'd1;
                changed <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_btn_value_counter.sv
// tb_btn_value_counter: random button sessions against a timeline model,
// scoreboard of expected (value, edge) pairs checked on every changed pulse.
module tb_btn_value_counter;

    localparam int D  = 4;
    localparam int RD = 20;
    localparam int RR = 5;
    localparam int G  = 10;

    logic       clk     = 1'b0;
    logic       rst     = 1'b1;
    logic       btn_up  = 1'b0;
    logic       btn_dn  = 1'b0;
    logic       btn_clr = 1'b0;
    logic [7:0] value;
    logic       changed;

    typedef struct {
        logic [7:0] val;
        int         cyc;
    } exp_t;

    exp_t       sb [$];
    exp_t       mon_e;
    int         cyc    = 0;
    int         total  = 0;
    int         passed = 0;
    logic [7:0] model  = 8'h00;

    btn_value_counter #(
        .DEBOUNCE_CYCLES(D),
        .DB_W           (3),
        .REPEAT_DELAY   (RD),
        .REPEAT_RATE    (RR)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .btn_up (btn_up),
        .btn_dn (btn_dn),
        .btn_clr(btn_clr),
        .value  (value),
        .changed(changed)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic push_step(input logic [7:0] v, input int e);
        exp_t x;
        x.val = v;
        x.cyc = e;
        sb.push_back(x);
    endtask

    // Buttons in mask m rise together after edge k and are seen high for hold edges.
    // Accepted press lands at k+D+3; repeats while debounced level is still high.
    task automatic model_op(input logic [2:0] m, input int k, input int hold);
        int p;
        int e;
        if (hold < D) return;
        p = k + D + 3;
        if (m[2]) begin
            model = 8'h00;
            push_step(model, p);
        end else if (m[0] && m[1]) begin
            model = model;
        end else if (m[0]) begin
            model = model + 8'd1;
            push_step(model, p);
        end else if (m[1]) begin
            model = model - 8'd1;
            push_step(model, p);
        end
`ifdef BTN_VALUE_COUNTER_AUTO_REPEAT_EN
        if (m[0] ^ m[1]) begin
            e = p + RD;
            while (e <= k + hold + D + 2) begin
                model = m[0] ? model + 8'd1 : model - 8'd1;
                push_step(model, e);
                e += RR;
            end
        end
`else
        e = 0;
`endif
    endtask

    task automatic press(input logic [2:0] m, input int hold, input int gap);
        @(negedge clk);
        model_op(m, cyc, hold);
        {btn_clr, btn_dn, btn_up} = m;
        repeat (hold) @(negedge clk);
        {btn_clr, btn_dn, btn_up} = 3'b000;
        repeat (gap) @(negedge clk);
        check("settled_value", int'(value), int'(model));
    endtask

    always @(negedge clk) begin
        if (!rst && changed) begin
            if (sb.size() == 0) begin
                check("unexpected_changed", int'(value), -1);
            end else begin
                mon_e = sb.pop_front();
                check("step_value", int'(value), int'(mon_e.val));
                check("step_cycle", cyc, mon_e.cyc);
            end
        end
    end

    initial begin
        int k;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (50) @(negedge clk);
        check("reset_value", int'(value), 0);
        check("reset_changed", int'(changed), 0);

        press(3'b001, 30, G);
`ifndef BTN_VALUE_COUNTER_AUTO_REPEAT_EN
        check("single_hold", int'(value), 1);
`endif

        @(negedge clk);
        btn_up = 1'b1;
        repeat (2) @(negedge clk);
        btn_up = 1'b0;
        repeat (2) @(negedge clk);
        btn_up = 1'b1;
        repeat (2) @(negedge clk);
        btn_up = 1'b0;
        repeat (2) @(negedge clk);
        press(3'b001, 10, G);
        press(3'b001, 3, G);

        press(3'b100, 6, G);
        press(3'b010, 6, G);
        check("wrap_dn", int'(value), 8'hFF);
        press(3'b001, 6, G);
        check("wrap_up", int'(value), 8'h00);
        press(3'b010, 6, G);
        press(3'b011, 6, G);
        check("up_dn_same", int'(value), 8'hFF);

        press(3'b100, 6, G);
        for (int i = 0; i < 66; i++) press(3'b001, 5, G);
        check("reach_42", int'(value), 8'h42);
        press(3'b101, 6, G);
        check("clr_up_same", int'(value), 8'h00);
        press(3'b100, 6, G);

        @(negedge clk);
        btn_up = 1'b1;
        repeat (3) @(negedge clk);
        rst    = 1'b1;
        btn_up = 1'b0;
        model  = 8'h00;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("rst_abort", int'(value), 0);

        rst    = 1'b1;
        btn_up = 1'b1;
        repeat (2) @(negedge clk);
        k     = cyc;
        rst   = 1'b0;
        model = 8'h00;
        model_op(3'b001, k, 10);
        repeat (10) @(negedge clk);
        btn_up = 1'b0;
        repeat (G) @(negedge clk);
        check("held_thru_reset", int'(value), int'(model));

        press(3'b100, 6, G);
        press(3'b001, 40, G);
`ifdef BTN_VALUE_COUNTER_AUTO_REPEAT_EN
        check("hold_40", int'(value), 5);
`else
        check("hold_40", int'(value), 1);
`endif

        for (int i = 0; i < 40; i++)
            press(3'($urandom_range(1, 7)), $urandom_range(1, 30), G);

        check("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
